// File: rtl/axi_master_rd_split_if.sv
// AXI4 read-address and read-data channel bundle between the split master and the interconnect.
// Only the signals this master needs are carried.
interface axi_master_rd_split_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 30
);
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_master_rd_split.sv
// AXI4 read master: splits one user read into INCR bursts (<= MAX_BURST beats, no 4 KB crossing),
// one burst in flight at a time, beats streamed straight to the user.
module axi_master_rd_split #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 30,
  parameter int LEN_W     = 12,
  parameter int MAX_BURST = 256,
  parameter int AXI_ID    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              rd_done,
  output logic              rd_err,
  output logic              m_axi_r_handshake,
  output logic [2:0]        o_dbg_state,
  axi_master_rd_split_if.master m_axi
);
  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
  // arvalid/araddr/arlen stay stable from assertion until that edge.
  localparam int BPB = DATA_W / 8;
  localparam int SZ  = $clog2(BPB);
  localparam int RW  = LEN_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(BPB - 1);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_AR, S_R, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cur_addr, w_cur_addr_nxt;
  logic [ADDR_W-1:0] r_araddr, w_araddr_nxt;
  logic [RW-1:0]     r_remaining, w_remaining_nxt;
  logic [8:0]        r_burst_beats, w_burst_beats_nxt;
  logic [8:0]        r_beat_cnt, w_beat_cnt_nxt;
  logic [7:0]        r_arlen, w_arlen_nxt;
  logic              r_arvalid, w_arvalid_nxt;
  logic              r_rready, w_rready_nxt;
  logic              r_err, w_err_nxt;
  logic [12:0]       w_to_4k;
  logic [31:0]       w_min;
  logic              w_hs;
  logic              w_last_expected;
  logic              w_unused;

  assign w_unused        = m_axi.rresp[0];
  assign w_hs            = m_axi.rvalid & r_rready;
  assign w_last_expected = (r_beat_cnt + 9'd1) == r_burst_beats;
  // Beats left before the next 4 KB page; at least 1 since cur_addr is beat-aligned.
  assign w_to_4k         = (13'd4096 - {1'b0, r_cur_addr[11:0]}) >> SZ;

  always_comb begin
    w_min = 32'(r_remaining);
    if (w_min > 32'(MAX_BURST)) w_min = 32'(MAX_BURST);
    if (w_min > 32'(w_to_4k))   w_min = 32'(w_to_4k);
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cur_addr_nxt    = r_cur_addr;
    w_araddr_nxt      = r_araddr;
    w_remaining_nxt   = r_remaining;
    w_burst_beats_nxt = r_burst_beats;
    w_beat_cnt_nxt    = r_beat_cnt;
    w_arlen_nxt       = r_arlen;
    w_arvalid_nxt     = r_arvalid;
    w_rready_nxt      = r_rready;
    w_err_nxt         = r_err;
    case (r_state)
      S_IDLE: begin
        if (rd_start) begin
          w_cur_addr_nxt  = rd_addr & ADDR_MASK;
          w_remaining_nxt = RW'(rd_len) + RW'(1);
          w_err_nxt       = 1'b0;
          w_state_nxt     = S_CALC;
        end
      end
      S_CALC: begin
        w_burst_beats_nxt = 9'(w_min);
        w_araddr_nxt      = r_cur_addr;
        w_arlen_nxt       = 8'(w_min - 32'd1);
        w_arvalid_nxt     = 1'b1;
        w_beat_cnt_nxt    = 9'd0;
        w_state_nxt       = S_AR;
      end
      S_AR: begin
        if (m_axi.arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_R;
        end
      end
      S_R: begin
        if (w_hs) begin
          w_beat_cnt_nxt = r_beat_cnt + 9'd1;
          // Slave error, or rlast disagreeing with the requested burst length.
          if (m_axi.rresp[1] || (m_axi.rlast != w_last_expected)) w_err_nxt = 1'b1;
          if (m_axi.rlast) begin
            w_rready_nxt    = 1'b0;
            w_cur_addr_nxt  = r_cur_addr + (ADDR_W'(r_burst_beats) << SZ);
            w_remaining_nxt = r_remaining - RW'(r_burst_beats);
            w_state_nxt     = (w_remaining_nxt == '0) ? S_DONE : S_CALC;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cur_addr    <= '0;
      r_araddr      <= '0;
      r_remaining   <= '0;
      r_burst_beats <= '0;
      r_beat_cnt    <= '0;
      r_arlen       <= '0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cur_addr    <= w_cur_addr_nxt;
      r_araddr      <= w_araddr_nxt;
      r_remaining   <= w_remaining_nxt;
      r_burst_beats <= w_burst_beats_nxt;
      r_beat_cnt    <= w_beat_cnt_nxt;
      r_arlen       <= w_arlen_nxt;
      r_arvalid     <= w_arvalid_nxt;
      r_rready      <= w_rready_nxt;
      r_err         <= w_err_nxt;
    end
  end

  assign rd_ready          = (r_state == S_IDLE);
  assign rd_done           = (r_state == S_DONE);
  assign rd_err            = r_err;
  assign m_axi_r_handshake = w_hs;
  assign rd_data_valid     = w_hs;
  assign rd_data           = w_hs ? m_axi.rdata : '0;
  assign o_dbg_state       = r_state;

  assign m_axi.arid    = 4'(AXI_ID);
  assign m_axi.araddr  = r_araddr;
  assign m_axi.arlen   = r_arlen;
  assign m_axi.arsize  = 3'(SZ);
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'b0010;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arqos   = 4'b0000;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.rready  = r_rready;
endmodule

// File: tb/tb_axi_master_rd_split.sv
// Directed bench for axi_master_rd_split: AXI slave responder, AR/data scoreboards, done/err checks.
module tb_axi_master_rd_split;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 30;
  localparam int LEN_W  = 12;
  localparam int BPB    = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd_start = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [LEN_W-1:0]  rd_len = '0;
  logic              rd_ready, rd_data_valid, rd_done, rd_err, m_axi_r_handshake;
  logic [DATA_W-1:0] rd_data;
  logic [2:0]        o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W+7:0] exp_ar_q[$];
  logic [DATA_W-1:0] exp_q[$];

  int cfg_ar_stall   = 0;
  bit cfg_gap        = 1'b0;
  int cfg_err_beat   = -1;
  int cfg_early_beat = -1;

  always #5 clk = ~clk;

  axi_master_rd_split_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) axi ();

  axi_master_rd_split #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_BURST(256), .AXI_ID(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_done(rd_done),
    .rd_err(rd_err), .m_axi_r_handshake(m_axi_r_handshake), .o_dbg_state(o_dbg_state),
    .m_axi(axi)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] a);
    return {32'(a) ^ 32'hC0DE0000, 32'(a) * 32'd2654435761};
  endfunction

  // Reference split: expected AR per burst and expected data per beat (first burst may end early).
  task automatic push_model(input logic [ADDR_W-1:0] addr, input int len);
    logic [ADDR_W-1:0] cur;
    int rem, b, to4k, n, beats;
    cur = addr & ~ADDR_W'(BPB - 1);
    rem = len + 1;
    b   = 0;
    while (rem > 0) begin
      to4k = (4096 - int'(cur[11:0])) / BPB;
      n = rem;
      if (n > 256)  n = 256;
      if (n > to4k) n = to4k;
      exp_ar_q.push_back({cur, 8'(n - 1)});
      beats = n;
      if (b == 0 && cfg_early_beat >= 0 && cfg_early_beat < n - 1) beats = cfg_early_beat + 1;
      for (int i = 0; i < beats; i++) exp_q.push_back(beat_data(cur + ADDR_W'(i * BPB)));
      cur = cur + ADDR_W'(n * BPB);
      rem = rem - n;
      b++;
    end
  endtask

  // AXI slave: decisions at posedge+2, transfers complete on the following posedge.
  initial begin : slave
    int stall, beat, burst, cur_burst;
    bit active, pend, pend_last, holding;
    logic [ADDR_W-1:0] s_addr;
    logic [7:0]        s_len;
    logic [ADDR_W+7:0] hold, exp_ar;
    stall = 0; beat = 0; burst = 0; cur_burst = 0;
    active = 0; pend = 0; pend_last = 0; holding = 0;
    s_addr = '0; s_len = '0; hold = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00; axi.rdata = '0;
    forever begin
      @(posedge clk); #2;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00; axi.rdata = '0;
      if (!rst_n) begin
        active = 0; pend = 0; holding = 0;
      end else begin
        if (rd_start && rd_ready) burst = 0;
        if (pend) begin
          pend = 0;
          beat++;
          if (pend_last) active = 0;
        end
        if (!active) begin
          if (holding && !axi.arvalid) begin
            check("ar_valid_held", axi.arvalid, 1);
            holding = 0;
          end
          if (axi.arvalid) begin
            if (!holding) begin
              holding = 1;
              hold    = {axi.araddr, axi.arlen};
              stall   = cfg_ar_stall;
            end else begin
              check("ar_hold_stable", {axi.araddr, axi.arlen}, hold);
            end
            if (stall > 0) begin
              stall--;
            end else begin
              axi.arready = 1'b1;
              holding = 0;
              if (exp_ar_q.size() == 0) begin
                check("ar_unexpected", 1, 0);
              end else begin
                exp_ar = exp_ar_q.pop_front();
                check("ar_addr", axi.araddr, exp_ar[ADDR_W+7:8]);
                check("ar_len", axi.arlen, exp_ar[7:0]);
              end
              check("ar_fixed_fields",
                    {axi.arid, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot, axi.arqos},
                    {4'd0, 3'd3, 2'b01, 1'b0, 4'b0010, 3'd0, 4'd0});
              s_addr = axi.araddr; s_len = axi.arlen;
              beat = 0; active = 1; cur_burst = burst; burst++;
            end
          end
        end else if (!cfg_gap || $urandom_range(0, 2) != 0) begin
          axi.rvalid = 1'b1;
          axi.rdata  = beat_data(s_addr + ADDR_W'(beat * BPB));
          axi.rresp  = (cur_burst == 0 && beat == cfg_err_beat) ? 2'b10 : 2'b00;
          axi.rlast  = (beat == int'(s_len)) || (cur_burst == 0 && beat == cfg_early_beat);
          pend       = axi.rready;
          pend_last  = axi.rlast;
        end
      end
    end
  end

  // Data scoreboard and done-latency monitor, sampled on the falling edge.
  initial begin : monitor
    bit prev_last;
    prev_last = 0;
    forever begin
      @(negedge clk);
      if (rd_data_valid) begin
        if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
        else check("rd_data", rd_data, exp_q.pop_front());
      end else begin
        check("rd_data_idle_zero", rd_data, 0);
      end
      if (rd_done) check("done_one_after_rlast", prev_last, 1);
      prev_last = rd_data_valid && axi.rlast;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_req(input string tag, input logic [ADDR_W-1:0] addr, input int len,
                         input logic exp_err);
    int waited;
    push_model(addr, len);
    check({tag, "_ready_before"}, rd_ready, 1);
    rd_addr = addr; rd_len = LEN_W'(len); rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    check({tag, "_arvalid_c1"}, axi.arvalid, 0);
    check({tag, "_err_cleared"}, rd_err, 0);
    @(posedge clk); #1;
    check({tag, "_arvalid_c2"}, axi.arvalid, 1);
    waited = 0;
    while (rd_done !== 1'b1 && waited < 5000) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, "_done_seen"}, rd_done, 1);
    check({tag, "_err"}, rd_err, exp_err);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, rd_done, 0);
    check({tag, "_ready_after"}, rd_ready, 1);
    check({tag, "_err_sticky"}, rd_err, exp_err);
    check({tag, "_ar_q_empty"}, exp_ar_q.size(), 0);
    check({tag, "_data_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin : main
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", o_dbg_state, 0);
    check("rst_ready", rd_ready, 1);
    check("rst_done", rd_done, 0);
    check("rst_err", rd_err, 0);
    check("rst_arvalid", axi.arvalid, 0);
    check("rst_rready", axi.rready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req("single", 30'h100, 15, 1'b0);
    run_req("maxsplit", 30'h0, 599, 1'b0);
    run_req("split4k", 30'hFC0, 15, 1'b0);

    cfg_ar_stall = 5;
    run_req("ar_stall", 30'h2000, 7, 1'b0);
    cfg_ar_stall = 0;

    cfg_gap = 1'b1;
    run_req("r_gaps", 30'h3009, 40, 1'b0);
    cfg_gap = 1'b0;

    cfg_err_beat = 2;
    run_req("rresp_err", 30'h4000, 7, 1'b1);
    cfg_err_beat = -1;
    run_req("err_clear", 30'h4100, 3, 1'b0);

    cfg_early_beat = 4;
    run_req("early_last", 30'hFC0, 15, 1'b1);
    cfg_early_beat = -1;

    push_model(30'h5000, 63);
    rd_addr = 30'h5000; rd_len = LEN_W'(63); rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_rst_in_r", o_dbg_state, 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_state", o_dbg_state, 0);
    check("mid_rst_rready", axi.rready, 0);
    check("mid_rst_arvalid", axi.arvalid, 0);
    check("mid_rst_done", rd_done, 0);
    check("mid_rst_err", rd_err, 0);
    check("mid_rst_ready", rd_ready, 1);
    rst_n = 1'b1;
    exp_ar_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    run_req("after_rst", 30'h6000, 9, 1'b0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/axi_master_rd_split.md
Name: axi_master_rd_split

Overview:
Parametrised AXI4 read master that takes one user read request of up to 2^LEN_W beats and splits it into legal INCR bursts. Each burst is at most MAX_BURST beats and never crosses a 4 KB boundary. It issues one burst at a time, streams returned beats to the user, and reports completion plus a sticky error status. It sits between user-side read logic (frame or FIFO readers) and the AXI interconnect to the DDR3 controller.

Parameters:
DATA_W, 64, AXI data width in bits (power of 2, 8..512); BPB = DATA_W/8 bytes per beat.
ADDR_W, 30, byte address width (>= 13).
LEN_W, 12, width of the user request length field.
MAX_BURST, 256, maximum beats per AXI burst (1..256).
AXI_ID, 0, constant value driven on m_axi_arid.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
rd_start  in  1  request strobe; accepted only when rd_ready=1
rd_addr  in  ADDR_W  start byte address; low log2(BPB) bits are ignored (treated as 0)
rd_len  in  LEN_W  total beats minus 1
rd_ready  out  1  high in IDLE only
rd_data  out  DATA_W  m_axi_rdata when m_axi_r_handshake, else 0
rd_data_valid  out  1  equals m_axi_r_handshake
rd_done  out  1  one-cycle pulse when the whole request has completed
rd_err  out  1  sticky error for the current/last request
m_axi_r_handshake  out  1  m_axi_rvalid & m_axi_rready
m_axi_arid  out  4  AXI_ID
m_axi_araddr  out  ADDR_W  burst address
m_axi_arlen  out  8  burst beats minus 1
m_axi_arsize  out  3  log2(BPB)
m_axi_arburst  out  2  2'b01 (INCR)
m_axi_arlock  out  1  0
m_axi_arcache  out  4  4'b0010
m_axi_arprot  out  3  0
m_axi_arqos  out  4  0
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  DATA_W  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat of the burst
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready

Behaviour:
- Reset: synchronous, checked at the clk edge with rst_n=0, highest priority, also mid-operation. All registered outputs go to 0, state goes to IDLE, and internal counters clear. An outstanding burst is abandoned because the interconnect is reset with this block.
- Internal registers:
  - cur_addr (ADDR_W)
  - remaining (LEN_W+1 bits)
  - burst_beats (9 bits)
  - beat_cnt (9 bits)
- IDLE: rd_ready=1. On rd_start, latch cur_addr=rd_addr with the low bits zeroed and remaining=rd_len+1 (no overflow, because remaining is LEN_W+1 bits wide), clear rd_err, then go to CALC. rd_start outside IDLE is ignored.
- CALC (1 cycle):
  - to_4k = (4096 - cur_addr[11:0]) >> log2(BPB)
  - burst_beats = min(remaining, MAX_BURST, to_4k)
  - Register m_axi_araddr=cur_addr, m_axi_arlen=burst_beats-1, m_axi_arvalid<=1, beat_cnt=0, then go to AR.
- AR: hold arvalid, araddr and arlen stable until m_axi_arready. On handshake: arvalid<=0, rready<=1, go to R.
- R: rready=1 for the whole state. On each r handshake: beat_cnt+=1; set rd_err if m_axi_rresp[1]=1.
  - Length check: rd_err is also set if rlast=1 with beat_cnt+1 != burst_beats, or rlast=0 with beat_cnt+1 == burst_beats.
  - The burst ends only on a handshake with rlast=1. Then: rready<=0, cur_addr += burst_beats*BPB, remaining -= burst_beats.
  - Exit: if the new remaining==0 go to DONE, else go to CALC.
- DONE: rd_done=1 for exactly one cycle, then go to IDLE. rd_err holds until the next accepted rd_start.
- Latency: rd_start accepted at cycle 0 → arvalid high at cycle 2. Last rlast handshake at cycle N → rd_done high at cycle N+1 and rd_ready high at cycle N+2.
- Only one burst is outstanding at a time. The next AR is issued 2 cycles after the previous rlast handshake (via CALC).
- rd_data and rd_data_valid are combinational from the R channel. The user must accept every beat.

Test Plan:
- Single burst: addr=0x100, rd_len=15, arready=1 → one AR with araddr=0x100, arlen=15; 16 rd_data_valid beats; rd_done 1 cycle after rlast; rd_err=0.
- Max-burst split: addr=0x0, rd_len=599 → ARs (0x000, arlen 255), (0x800, 255), (0x1000, 87); 600 beats total; a single rd_done.
- 4 KB split: addr=0xFC0, rd_len=15 → (0xFC0, arlen 7) then (0x1000, arlen 7); no burst crosses 0x1000.
- Backpressure and errors:
  - arready low for 5 cycles → arvalid, araddr and arlen held constant.
  - rvalid gaps → beat count correct.
  - rresp=2'b10 on beat 3 → rd_err=1 at rd_done; next rd_start clears it.
- Early rlast on beat 5 of an 8-beat burst → rd_err=1, burst ends, the remaining request continues from cur_addr+8*BPB.
- rst_n=0 for 1 cycle during R → next cycle state IDLE, rready=0, arvalid=0, rd_done=0, rd_err=0, rd_ready=1; a new request then completes normally.
